// File: rtl/pair_area_scheduler.sv
// pair_area_scheduler: walks every unordered pair (i<j) of an N-point set in
// row-major order, issues each over a valid/ready link, tracks in-flight pairs
// in an in-order tag FIFO and keeps the running maximum area and its pair.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                level; high in IDLE begins a sweep
//   busy / finished      high in ISSUE|DRAIN / high in DONE
//   pair_valid/ready     issue handshake; pair_i < pair_j
//   area_valid, area     one returned area per cycle, in issue order
//   best_area/i/j        running maximum (strict >, ties keep earliest)
//   pair_count           pairs retired this sweep
//   proto_err            sticky: area_valid with nothing in flight
module pair_area_scheduler #(
   parameter int NUM_ELEMENTS    = 496,
   parameter int IDX_W           = 16,
   parameter int AREA_W          = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              finished,
   output logic              pair_valid,
   input  logic              pair_ready,
   output logic [IDX_W-1:0]  pair_i,
   output logic [IDX_W-1:0]  pair_j,
   input  logic              area_valid,
   input  logic [AREA_W-1:0] area,
   output logic [AREA_W-1:0] best_area,
   output logic [IDX_W-1:0]  best_i,
   output logic [IDX_W-1:0]  best_j,
   output logic [31:0]       pair_count,
   output logic              proto_err
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_ELEMENTS - 2);
   localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_ELEMENTS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic               r_pair_valid;
   logic [IDX_W-1:0]   r_pair_i;
   logic [IDX_W-1:0]   r_pair_j;
   logic [AREA_W-1:0]  r_best_area;
   logic [IDX_W-1:0]   r_best_i;
   logic [IDX_W-1:0]   r_best_j;
   logic [31:0]        r_pair_count;
   logic               r_proto_err;
   logic [IDX_W-1:0]   r_fifo_i [MAX_OUTSTANDING];
   logic [IDX_W-1:0]   r_fifo_j [MAX_OUTSTANDING];
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [CW-1:0]      r_out;

   logic               w_push;
   logic               w_pop;
   logic               w_spurious;
   logic [CW-1:0]      w_out_nxt;
   logic               w_room;
   logic               w_last;
   logic               w_row_end;
   logic               w_better;
   logic [IDX_W-1:0]   w_tag_i;
   logic [IDX_W-1:0]   w_tag_j;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push     = r_pair_valid & pair_ready;
   assign w_pop      = area_valid & (r_out != '0);
   assign w_spurious = area_valid & (r_out == '0);
   assign w_out_nxt  = r_out + CW'(w_push) - CW'(w_pop);
   // Valid for the next cycle is decided from the post-update occupancy,
   // so pair_ready never reaches pair_valid combinationally.
   assign w_room     = (w_out_nxt < CW'(MAX_OUTSTANDING));
   assign w_last     = (r_pair_i == LAST_I) && (r_pair_j == LAST_J);
   assign w_row_end  = (r_pair_j == LAST_J);
   assign w_tag_i    = r_fifo_i[r_rptr];
   assign w_tag_j    = r_fifo_j[r_rptr];
   assign w_better   = (area > r_best_area);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pair_valid <= 1'b0;
         r_pair_i     <= '0;
         r_pair_j     <= '0;
         r_best_area  <= '0;
         r_best_i     <= '0;
         r_best_j     <= '0;
         r_pair_count <= '0;
         r_proto_err  <= 1'b0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_out        <= '0;
         for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            r_fifo_i[k] <= '0;
            r_fifo_j[k] <= '0;
         end
      end else begin
         r_out <= w_out_nxt;

         if (w_push) begin
            r_fifo_i[r_wptr] <= r_pair_i;
            r_fifo_j[r_wptr] <= r_pair_j;
            r_wptr           <= f_inc(r_wptr);
         end

         if (w_pop) begin
            r_rptr       <= f_inc(r_rptr);
            r_pair_count <= r_pair_count + 32'd1;
            if (w_better) begin
               r_best_area <= area;
               r_best_i    <= w_tag_i;
               r_best_j    <= w_tag_j;
            end
         end

         if (w_spurious) begin
            r_proto_err <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_pair_valid <= 1'b0;
               if (start) begin
                  // Later assignments here override the retire/error
                  // updates above: a new sweep starts from a clean slate.
                  r_best_area  <= '0;
                  r_best_i     <= '0;
                  r_best_j     <= '0;
                  r_pair_count <= '0;
                  r_proto_err  <= 1'b0;
                  r_pair_i     <= '0;
                  if (NUM_ELEMENTS < 2) begin
                     r_pair_j <= '0;
                     r_state  <= S_DONE;
                  end else begin
                     r_pair_j     <= IDX_W'(1);
                     r_pair_valid <= 1'b1;
                     r_state      <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (w_push && w_last) begin
                  r_pair_valid <= 1'b0;
                  r_state      <= S_DRAIN;
               end else begin
                  r_pair_valid <= w_room;
                  if (w_push) begin
                     if (w_row_end) begin
                        r_pair_i <= r_pair_i + IDX_W'(1);
                        r_pair_j <= r_pair_i + IDX_W'(2);
                     end else begin
                        r_pair_j <= r_pair_j + IDX_W'(1);
                     end
                  end
               end
            end
            S_DRAIN: begin
               r_pair_valid <= 1'b0;
               if (w_out_nxt == '0) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_pair_valid <= 1'b0;
               if (!start) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_pair_valid <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign finished   = (r_state == S_DONE);
   assign pair_valid = r_pair_valid;
   assign pair_i     = r_pair_i;
   assign pair_j     = r_pair_j;
   assign best_area  = r_best_area;
   assign best_i     = r_best_i;
   assign best_j     = r_best_j;
   assign pair_count = r_pair_count;
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_pair_area_scheduler.sv
// tb_pair_area_scheduler: randomized sweeps of pair_area_scheduler against a
// queue-based pair/area reference with a decoupled handshake monitor.
module tb_pair_area_scheduler;

   localparam int N    = 9;
   localparam int IW   = 16;
   localparam int AW   = 64;
   localparam int MAXO = 4;
   localparam int NP   = N * (N - 1) / 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy;
   logic          finished;
   logic          pair_valid;
   logic          pair_ready = 1'b0;
   logic [IW-1:0] pair_i;
   logic [IW-1:0] pair_j;
   logic          area_valid = 1'b0;
   logic [AW-1:0] area = '0;
   logic [AW-1:0] best_area;
   logic [IW-1:0] best_i;
   logic [IW-1:0] best_j;
   logic [31:0]   pair_count;
   logic          proto_err;

   pair_area_scheduler #(
      .NUM_ELEMENTS   (N),
      .IDX_W          (IW),
      .AREA_W         (AW),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .finished  (finished),
      .pair_valid(pair_valid),
      .pair_ready(pair_ready),
      .pair_i    (pair_i),
      .pair_j    (pair_j),
      .area_valid(area_valid),
      .area      (area),
      .best_area (best_area),
      .best_i    (best_i),
      .best_j    (best_j),
      .pair_count(pair_count),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] i;
      logic [IW-1:0] j;
      logic [AW-1:0] a;
   } ent_t;

   ent_t          exp_q[$];
   logic [AW-1:0] dp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cnt_hs = 0;
   int            cnt_ret = 0;
   bit            ret_pending = 0;
   bit            spur = 0;
   bit            bp = 0;
   bit            stall = 0;
   bit            prev_stall = 0;
   logic [IW-1:0] prev_i, prev_j;
   logic [AW-1:0] m_best;
   logic [IW-1:0] m_bi, m_bj;

   task automatic chk(input string nm, input logic [AW-1:0] act,
                      input logic [AW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Datapath model: returns areas in order, one per cycle at most.
   always @(posedge clk) begin
      #1;
      area_valid  = 1'b0;
      ret_pending = 0;
      if (spur) begin
         area_valid = 1'b1;
         area       = 64'd77;
         spur       = 0;
      end else if (dp_q.size() > 0 &&
                   (!stall || $urandom_range(0, 2) == 0)) begin
         area        = dp_q.pop_front();
         area_valid  = 1'b1;
         ret_pending = 1;
         cnt_ret++;
      end
      pair_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: every handshake is checked against the expected pair order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("stall_valid", pair_valid, 1);
            chk("stall_i", pair_i, prev_i);
            chk("stall_j", pair_j, prev_j);
         end
         if (pair_valid) begin
            chk("inflight_lt_max",
                (cnt_hs - (cnt_ret - int'(ret_pending))) < MAXO, 1);
            if (pair_ready) begin
               cnt_hs++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL extra_pair: got (%0d,%0d), want none",
                           pair_i, pair_j);
                  dp_q.push_back('0);
               end else begin
                  ent_t e;
                  e = exp_q.pop_front();
                  chk("pair_i", pair_i, e.i);
                  chk("pair_j", pair_j, e.j);
                  dp_q.push_back(e.a);
               end
            end
         end
         prev_stall = pair_valid && !pair_ready;
         prev_i     = pair_i;
         prev_j     = pair_j;
      end else begin
         prev_stall = 0;
      end
   end

   // Reference: all pairs i<j in row-major order, max by strict compare.
   task automatic prep(input int mode);
      int px[N];
      int py[N];
      int k;
      int dx, dy;
      logic [AW-1:0] a;
      exp_q.delete();
      m_best = '0;
      m_bi   = '0;
      m_bj   = '0;
      for (int p = 0; p < N; p++) begin
         px[p] = $urandom_range(0, 999);
         py[p] = $urandom_range(0, 999);
      end
      k = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = i + 1; j < N; j++) begin
            if (mode == 0) begin
               case (k)
                  0: a = 64'd5;
                  1: a = 64'd9;
                  2: a = 64'd9;
                  3: a = 64'd3;
                  default: a = 64'($urandom_range(0, 8));
               endcase
            end else if (mode == 1) begin
               dx = px[i] - px[j];
               dy = py[i] - py[j];
               if (dx < 0) dx = -dx;
               if (dy < 0) dy = -dy;
               a = 64'(dx + 1) * 64'(dy + 1);
            end else begin
               a = {$urandom, $urandom};
            end
            if (a > m_best) begin
               m_best = a;
               m_bi   = IW'(i);
               m_bj   = IW'(j);
            end
            exp_q.push_back('{i: IW'(i), j: IW'(j), a: a});
            k++;
         end
      end
   endtask

   task automatic wait_finished();
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (finished) break;
      end
      chk("finished_reached", finished, 1);
   endtask

   task automatic run_sweep(input int mode, input bit bpv, input bit stv);
      prep(mode);
      bp    = bpv;
      stall = stv;
      @(negedge clk);
      start = 1'b1;
      wait_finished();
      chk("pair_count", pair_count, NP);
      chk("best_area", best_area, m_best);
      chk("best_i", best_i, m_bi);
      chk("best_j", best_j, m_bj);
      chk("proto_err_clear", proto_err, 0);
      chk("pairs_left", exp_q.size(), 0);
      chk("busy_done", busy, 0);
      repeat (3) @(negedge clk);
      chk("finished_held", finished, 1);
      chk("best_held", best_area, m_best);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("finished_drop", finished, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", pair_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_finished", finished, 0);
      chk("rst_best", best_area, 0);
      chk("rst_count", pair_count, 0);
      chk("rst_perr", proto_err, 0);
      rst_n = 1'b1;

      @(negedge clk);
      spur = 1;
      repeat (3) @(negedge clk);
      chk("spur_perr", proto_err, 1);
      chk("spur_count", pair_count, 0);

      run_sweep(0, 0, 0);
      run_sweep(1, 0, 0);
      run_sweep(2, 1, 1);
      run_sweep(1, 1, 1);
      run_sweep(2, 0, 1);
      run_sweep(0, 1, 1);

      prep(1);
      bp    = 1;
      stall = 1;
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (cnt_hs >= 10) break;
      end
      chk("mid_progress", cnt_hs >= 10, 1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      dp_q.delete();
      #1;
      chk("arst_valid", pair_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_count", pair_count, 0);
      chk("arst_best", best_area, 0);
      chk("arst_i", pair_i, 0);
      start = 1'b0;
      repeat (3) @(negedge clk);
      dp_q.delete();
      cnt_hs  = 0;
      cnt_ret = 0;
      rst_n   = 1'b1;
      run_sweep(1, 1, 0);
      run_sweep(2, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
